alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_comb.sv | 83 ++++++++
 rtl/alu.sv | 47 ++++
 tb/tb_alu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and default operand width.
// No logic; constants and types only.
// Backpressure: not applicable.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    // Reserved encodings (1010, 1011, 1111) are named so a case statement
    // over op_t can spell out every value.
    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_NOR   = 4'b0101,
        OP_EQ    = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MUL   = 4'b1000,
        OP_ASR   = 4'b1001,
        OP_RSV_A = 4'b1010,
        OP_RSV_B = 4'b1011,
        OP_SLL   = 4'b1100,
        OP_SRL   = 4'b1101,
        OP_NOT   = 4'b1110,
        OP_RSV_F = 4'b1111
    } op_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: result and status flag for one operation.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows inputs every cycle.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             flag
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [SHW-1:0]     sh;
    logic               mul_ovf;
    logic               lt;

    assign sum  = a + b;
    assign diff = a - b;
    // Both operands sign-extended to the full product width, so the
    // truncated 2W-bit product is the exact signed product.
    assign prod = {{WIDTH{a[MSB]}}, a} * {{WIDTH{b[MSB]}}, b};
    // The product fits in WIDTH bits only if its top W+1 bits are all copies of the sign.
    assign mul_ovf = (prod[2*WIDTH-1:MSB] != {(WIDTH+1){prod[MSB]}});
    assign sh   = b[SHW-1:0];
    assign lt   = $signed(a) < $signed(b);

    // Select the result and per-opcode flag meaning.
    always_comb begin
        res  = '0;
        flag = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                res  = sum;
                flag = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                res  = diff;
                flag = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND: begin res = a & b;    flag = (res == '0); end
            OP_OR:  begin res = a | b;    flag = (res == '0); end
            OP_XOR: begin res = a ^ b;    flag = (res == '0); end
            OP_NOR: begin res = ~(a | b); flag = (res == '0); end
            OP_EQ: begin
                res  = {{(WIDTH-1){1'b0}}, (a == b)};
                flag = (a == b);
            end
            OP_SLT: begin
                res  = {{(WIDTH-1){1'b0}}, lt};
                flag = lt;
            end
            OP_MUL: begin
                res  = prod[MSB:0];
                flag = mul_ovf;
            end
            OP_ASR: begin
                res  = $unsigned($signed(a) >>> sh);
                flag = (res == '0);
            end
            OP_SLL: begin res = a << sh; flag = (res == '0); end
            OP_SRL: begin res = a >> sh; flag = (res == '0); end
            OP_NOT: begin res = ~a;      flag = (res == '0); end
            OP_RSV_A, OP_RSV_B, OP_RSV_F: begin
                res  = '0;
                flag = 1'b0;
            end
            default: begin
                res  = '0;
                flag = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU: one operation per cycle, result and flag held between ops.
// Latency: 1 cycle from in_valid edge to out_valid.
// Backpressure: none; accepts every in_valid beat back-to-back.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opCode,
    input  logic             in_valid,
    output logic [WIDTH-1:0] cout,
    output logic             flag,
    output logic             out_valid
);

    logic [WIDTH-1:0] res;
    logic             res_flag;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a    (A),
        .b    (B),
        .op   (opCode),
        .res  (res),
        .flag (res_flag)
    );

    // Output register: load on valid, otherwise hold; reset wins over any
    // operation presented while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cout      <= '0;
            flag      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                cout <= res;
                flag <= res_flag;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, random traffic, reset cases.
// Latency modelled: 1 cycle.
// Backpressure: none.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  opCode = '0;
    logic        in_valid = 1'b0;
    logic [15:0] cout;
    logic        flag;
    logic        out_valid;

    int total = 0;
    int passed = 0;
    bit started = 0;

    alu #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .opCode    (opCode),
        .in_valid  (in_valid),
        .cout      (cout),
        .flag      (flag),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model from plain integer arithmetic; returns {flag, result}.
    function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        longint sa, sb, ua, r, p2;
        logic [15:0] c;
        logic        f;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        p2 = longint'(1) << b[3:0];
        c = '0;
        f = 1'b0;
        case (op)
            4'd0: begin r = sa + sb; c = r[15:0]; f = (r > 32767) || (r < -32768); end
            4'd1: begin r = sa - sb; c = r[15:0]; f = (r > 32767) || (r < -32768); end
            4'd2: begin c = a & b;    f = (c == 16'd0); end
            4'd3: begin c = a | b;    f = (c == 16'd0); end
            4'd4: begin c = a ^ b;    f = (c == 16'd0); end
            4'd5: begin c = ~(a | b); f = (c == 16'd0); end
            4'd6: begin c = {15'd0, (sa == sb)}; f = c[0]; end
            4'd7: begin c = {15'd0, (sa < sb)};  f = c[0]; end
            4'd8: begin r = sa * sb; c = r[15:0]; f = (r > 32767) || (r < -32768); end
            4'd9: begin
                // floor division by 2^sh
                if (sa < 0) r = -((-sa + p2 - 1) / p2);
                else        r = sa / p2;
                c = r[15:0];
                f = (c == 16'd0);
            end
            4'd12: begin r = ua * p2; c = r[15:0]; f = (c == 16'd0); end
            4'd13: begin r = ua / p2; c = r[15:0]; f = (c == 16'd0); end
            4'd14: begin c = ~a; f = (c == 16'd0); end
            default: begin c = 16'd0; f = 1'b0; end
        endcase
        return {f, c};
    endfunction

    // Model of the registered outputs, driven only by the bench's own inputs.
    logic        m_valid = 1'b0;
    logic [15:0] m_cout = '0;
    logic        m_flag = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_cout  = '0;
            m_flag  = 1'b0;
        end else begin
            m_valid = in_valid;
            if (in_valid) {m_flag, m_cout} = model(opCode, A, B);
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("cout",      {16'd0, cout},      {16'd0, m_cout});
            chk("flag",      {31'd0, flag},      {31'd0, m_flag});
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic        f;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic f);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.c = c; v.f = f;
        vecs.push_back(v);
    endtask

    initial begin
        // Hand-computed expectations.
        add_vec(4'b0000, 16'd10,     16'd20,     16'h001E, 1'b0);
        add_vec(4'b0000, -16'sd110,  -16'sd20,   16'hFF7E, 1'b0);
        add_vec(4'b0000, 16'h7FFF,   16'd1,      16'h8000, 1'b1);
        add_vec(4'b0000, 16'h8000,   16'h8000,   16'h0000, 1'b1);
        add_vec(4'b0001, 16'd100,    16'd20,     16'h0050, 1'b0);
        add_vec(4'b0001, 16'd10,     -16'sd20,   16'h001E, 1'b0);
        add_vec(4'b0001, 16'h8000,   16'd1,      16'h7FFF, 1'b1);
        add_vec(4'b0010, 16'd100,    16'd20,     16'h0004, 1'b0);
        add_vec(4'b0011, 16'd10,     -16'sd20,   16'hFFEE, 1'b0);
        add_vec(4'b0100, 16'd10,     -16'sd20,   16'hFFE6, 1'b0);
        add_vec(4'b0101, 16'd10,     -16'sd20,   16'h0011, 1'b0);
        add_vec(4'b0110, 16'd10,     16'd20,     16'h0000, 1'b0);
        add_vec(4'b0110, 16'd10,     16'd10,     16'h0001, 1'b1);
        add_vec(4'b0111, 16'd10,     16'd10,     16'h0000, 1'b0);
        add_vec(4'b0111, 16'd10,     16'd140,    16'h0001, 1'b1);
        add_vec(4'b0111, -16'sd10,   16'd10,     16'h0001, 1'b1);
        add_vec(4'b1000, -16'sd10,   16'd10,     16'hFF9C, 1'b0);
        add_vec(4'b1000, 16'h4000,   16'd4,      16'h0000, 1'b1);
        add_vec(4'b1001, -16'sd10,   16'd10,     16'hFFFF, 1'b0);
        add_vec(4'b1001, 16'h8000,   16'h0011,   16'hC000, 1'b0);
        add_vec(4'b1100, 16'd64,     16'd10,     16'h0000, 1'b1);
        add_vec(4'b1101, 16'd64,     16'd2,      16'h0010, 1'b0);
        add_vec(4'b1101, 16'h8000,   16'd15,     16'h0001, 1'b0);
        add_vec(4'b1110, 16'd10,     16'd0,      16'hFFF5, 1'b0);
        add_vec(4'b1010, 16'd5,      16'd3,      16'h0000, 1'b0);
        add_vec(4'b1111, 16'hFFFF,   16'hFFFF,   16'h0000, 1'b0);

        // Reset state before the first edge.
        #1;
        chk("rst_cout",  {16'd0, cout},      32'd0);
        chk("rst_flag",  {31'd0, flag},      32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);

        @(posedge clk); #3 rst = 1'b0;
        started = 1;

        // Pin the model against the literal table.
        foreach (vecs[i]) begin
            logic [16:0] m;
            m = model(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("model_%0d", i), {15'd0, m}, {15'd0, vecs[i].f, vecs[i].c});
        end

        // Directed vectors back-to-back; each result checked one edge later.
        for (int i = 0; i <= vecs.size(); i++) begin
            @(posedge clk); #2;
            if (i > 0) begin
                chk($sformatf("vec%0d_cout", i-1), {16'd0, cout}, {16'd0, vecs[i-1].c});
                chk($sformatf("vec%0d_flag", i-1), {31'd0, flag}, {31'd0, vecs[i-1].f});
                chk($sformatf("vec%0d_valid", i-1), {31'd0, out_valid}, 32'd1);
            end
            if (i < vecs.size()) begin
                A = vecs[i].a; B = vecs[i].b; opCode = vecs[i].op; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end

        // Idle cycles with changing operands: outputs must hold.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            A = 16'(i * 977); B = 16'(i + 3); opCode = 4'(i);
        end
        chk("hold_cout",  {16'd0, cout},      {16'd0, vecs[vecs.size()-1].c});
        chk("hold_valid", {31'd0, out_valid}, 32'd0);

        // Random traffic with random gaps.
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #2;
            A = 16'($urandom); B = 16'($urandom);
            opCode = 4'($urandom_range(0, 15));
            in_valid = 1'($urandom_range(0, 3) != 0);
        end

        // Known nonzero result, then reset between edges.
        @(posedge clk); #2;
        A = 16'd10; B = 16'd20; opCode = 4'b0000; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_cout",  {16'd0, cout},      32'd0);
        chk("midrst_flag",  {31'd0, flag},      32'd0);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        A = 16'h7FFF; B = 16'd1; opCode = 4'b0000; in_valid = 1'b1;
        @(posedge clk); #3;
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #2;
        chk("postrst_valid", {31'd0, out_valid}, 32'd0);
        chk("postrst_cout",  {16'd0, cout},      32'd0);
        A = 16'd64; B = 16'd2; opCode = 4'b1101; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        chk("first_cout",  {16'd0, cout},      32'h0010);
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #2;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
